multicycle_ctrl_hs: RTL and testbench
=====================================

Name: multicycle_ctrl_hs

Overview:
- Second-generation control FSM for the multi-cycle MIPS-subset CPU.
- Replaces fixed single-cycle memory timing with a MemRead/MemWrite-to-mem_ready handshake, plus a parametrised timeout.
- Adds bne, a register-target PC source for jr/jalr, and an illegal-opcode/bus-timeout trap.
- Outputs are Moore-decoded from the state register plus OpCode/Funct; it drives the existing multi-cycle datapath.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for mem_ready per access; 0 disables the timeout.
- TRAP_HALT, 0: 1 = enter S_HALT after a trap; 0 = refetch from the trap vector.
- ENABLE_BNE, 1: 1 = decode bne (opcode 6'h05); 0 = bne is illegal.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- OpCode, input, 6: IR[31:26].
- Funct, input, 6: IR[5:0].
- mem_ready, input, 1: memory completes the current access this cycle.
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp: output, 1 each: datapath controls.
- MemtoReg, RegDst, ALUSrcA, ALUSrcB: output, 2 each; encodings as in the current datapath.
- ALUOp, output, 4: ALU control.
- PCSource, output, 3:
  - 000 ALU result
  - 001 ALUOut
  - 010 jump immediate
  - 011 rs register
  - 100 trap vector
- trap, output, 1: one-cycle pulse when a trap is taken.
- trap_cause, output, 2: 01 illegal opcode, 10 memory timeout; held until the next trap or reset.
- instr_retired, output, 1: one-cycle pulse on the final cycle of each completed instruction.
- state_dbg, output, 4: current state encoding.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - Asserting reset in any state, including mid-handshake, forces S_IDLE on the next edge and clears the timeout counter and trap_cause.
  - In S_IDLE all outputs are 0.
  - S_IDLE moves to S_FETCH on the first edge with reset low.
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP, S_HALT.
- Outputs not listed for a state are 0.
- S_FETCH:
  - MemRead=1, IorD=0.
  - While mem_ready=0, stay.
  - In the cycle mem_ready=1, also assert IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=01, PCSource=000, then go to S_DECODE.
- S_DECODE:
  - ALUSrcA=00, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut).
  - Next state by instruction:
    - R-type with Funct jr (08) or jalr (09) -> S_JUMP.
    - Other R-type, addi/addiu/andi/slti/sltiu/lui -> S_EXEC.
    - lw/sw -> S_MEM_ADDR.
    - beq, and bne if ENABLE_BNE -> S_BRANCH.
    - j/jal -> S_JUMP.
    - Anything else -> S_TRAP with cause 01.
- S_EXEC:
  - Shifts (Funct 00/02/03): ALUSrcA=10, ExtOp=0.
  - Otherwise ALUSrcA=01, ExtOp=1.
  - ALUSrcB=00 for R-type, 10 for immediates.
  - LuiOp=1 only for lui.
  - Next state S_WB_ALU.
- ALUOp in S_EXEC/S_BRANCH:
  - ALUOp[3]=OpCode[0].
  - ALUOp[2:0]: R-type 010, beq/bne 001, andi 100, slti/sltiu 101, else 000.
  - ALUOp=0000 in all other states.
- S_WB_ALU: RegWrite=1, MemtoReg=01, RegDst=01 for R-type and 00 for immediates; instr_retired=1; next S_FETCH.
- S_MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1; next S_MEM_RD for lw, S_MEM_WR for sw.
- S_MEM_RD: MemRead=1, IorD=1; wait for mem_ready, then go to S_WB_MEM.
- S_WB_MEM: RegWrite=1, MemtoReg=00, RegDst=00; instr_retired=1; next S_FETCH.
- S_MEM_WR: MemWrite=1, IorD=1; wait for mem_ready; that cycle pulses instr_retired and goes to S_FETCH.
- S_BRANCH: ALUSrcA=01, ALUSrcB=00, PCWriteCond=1, PCSource=001, BranchNe=(OpCode==05); instr_retired=1; next S_FETCH.
- S_JUMP:
  - PCWrite=1; instr_retired=1; next S_FETCH.
  - PCSource=010 for j/jal, 011 for jr/jalr.
  - jal additionally drives RegWrite=1, RegDst=10, MemtoReg=10.
  - jalr additionally drives RegWrite=1, RegDst=01, MemtoReg=10.
- Memory timeout:
  - The counter increments each cycle spent in S_FETCH/S_MEM_RD/S_MEM_WR with mem_ready=0, and clears on state exit.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, go to S_TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: normal completion, no trap.
- S_TRAP: trap=1, PCWrite=1, PCSource=100; next S_HALT if TRAP_HALT, else S_FETCH.
- S_HALT: all outputs 0; exit only via reset.
- No instr_retired pulse for trapped instructions.

Test Plan:
- Reset with mem_ready tied 1, then addi (OpCode 08): states IDLE, FETCH, DECODE, EXEC, WB_ALU. In WB_ALU, RegWrite=1, RegDst=00, MemtoReg=01; instr_retired pulses once. Fetch-to-retire is 4 cycles.
- lw with mem_ready delayed 3 cycles in S_MEM_RD: MemRead=1 and IorD=1 are held for 4 cycles; WB_MEM follows the ready cycle with MemtoReg=00.
- bne (05), ENABLE_BNE=1: in S_BRANCH, PCWriteCond=1, BranchNe=1, PCSource=001, ALUOp=1001. With ENABLE_BNE=0, the same opcode gives trap=1, trap_cause=01, PCSource=100.
- jalr (OpCode 00, Funct 09): S_JUMP drives PCWrite=1, PCSource=011, RegWrite=1, RegDst=01, MemtoReg=10.
- sw, MEM_TIMEOUT=15, mem_ready held 0: trap is entered after 15 wait cycles with trap_cause=10. Repeat with mem_ready=1 on cycle 15: no trap, retires normally.
- Reset asserted in S_MEM_WR mid-wait: MemWrite=0 the next cycle, state_dbg shows S_IDLE, trap_cause=00, and the FSM resumes at S_FETCH after reset drops.

Source files
------------

// File: rtl/multicycle_ctrl_hs_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_hs_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ExtOp;
  logic       LuiOp;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [2:0] PCSource;
  logic       trap;
  logic [1:0] trap_cause;
  logic       instr_retired;
  logic [3:0] state_dbg;

  // Memory handshake: MemRead/MemWrite is held until the cycle mem_ready=1,
  // which completes the access; there is no separate ready-to-accept phase.
  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, trap, trap_cause, instr_retired, state_dbg
  );

  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, trap, trap_cause, instr_retired, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle MIPS-subset control FSM with memory handshake, bus timeout
// and illegal-opcode trap.
module multicycle_ctrl_hs #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_HALT   = 1'b0,
  parameter bit ENABLE_BNE  = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_ctrl_hs_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;

  logic       is_rtype, is_jr_funct, is_shift, is_imm_alu, is_lui;
  logic       is_lw, is_sw, is_beq, is_bne_raw, is_bne, is_j, is_jal;
  logic       timeout_hit;
  state_e     done_state;
  logic [2:0] alu_func;

  assign is_rtype    = (bus.OpCode == 6'h00);
  assign is_jr_funct = (bus.Funct == 6'h08) || (bus.Funct == 6'h09);
  assign is_shift    = is_rtype && ((bus.Funct == 6'h00) || (bus.Funct == 6'h02) ||
                                    (bus.Funct == 6'h03));
  assign is_lui      = (bus.OpCode == 6'h0F);
  assign is_imm_alu  = (bus.OpCode == 6'h08) || (bus.OpCode == 6'h09) ||
                       (bus.OpCode == 6'h0A) || (bus.OpCode == 6'h0B) ||
                       (bus.OpCode == 6'h0C) || is_lui;
  assign is_lw       = (bus.OpCode == 6'h23);
  assign is_sw       = (bus.OpCode == 6'h2B);
  assign is_beq      = (bus.OpCode == 6'h04);
  assign is_bne_raw  = (bus.OpCode == 6'h05);
  assign is_bne      = is_bne_raw && ENABLE_BNE;
  assign is_j        = (bus.OpCode == 6'h02);
  assign is_jal      = (bus.OpCode == 6'h03);

  // Timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a ready
  // in that same cycle still completes normally.
  assign timeout_hit = (MEM_TIMEOUT > 0) && !bus.mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    done_state = S_FETCH;
    if (state_q == S_FETCH)       done_state = S_DECODE;
    else if (state_q == S_MEM_RD) done_state = S_WB_MEM;
  end

  always_comb begin
    alu_func = 3'b000;
    if (is_rtype)                       alu_func = 3'b010;
    else if (is_beq || is_bne_raw)      alu_func = 3'b001;
    else if (bus.OpCode == 6'h0C)       alu_func = 3'b100;
    else if ((bus.OpCode == 6'h0A) || (bus.OpCode == 6'h0B)) alu_func = 3'b101;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = done_state;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_rtype)                state_d = is_jr_funct ? S_JUMP : S_EXEC;
        else if (is_imm_alu)         state_d = S_EXEC;
        else if (is_lw || is_sw)     state_d = S_MEM_ADDR;
        else if (is_beq || is_bne)   state_d = S_BRANCH;
        else if (is_j || is_jal)     state_d = S_JUMP;
        else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC:     state_d = S_WB_ALU;
      S_WB_ALU:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = is_sw ? S_MEM_WR : S_MEM_RD;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = TRAP_HALT ? S_HALT : S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, ext_op, lui_op, trap_o, retired;
  logic [1:0] memto_reg, reg_dst, alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] pc_source;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    ext_op        = 1'b0;
    lui_op        = 1'b0;
    trap_o        = 1'b0;
    retired       = 1'b0;
    memto_reg     = 2'b00;
    reg_dst       = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    pc_source     = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC: begin
        alu_src_a = is_shift ? 2'b10 : 2'b01;
        ext_op    = !is_shift;
        alu_src_b = is_rtype ? 2'b00 : 2'b10;
        lui_op    = is_lui;
        alu_op    = {bus.OpCode[0], alu_func};
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        memto_reg = 2'b01;
        reg_dst   = is_rtype ? 2'b01 : 2'b00;
        retired   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retired   = bus.mem_ready;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 3'b001;
        branch_ne     = is_bne_raw;
        alu_op        = {bus.OpCode[0], alu_func};
        retired       = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        retired   = 1'b1;
        pc_source = is_rtype ? 3'b011 : 3'b010;
        if (is_jal) begin
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          memto_reg = 2'b10;
        end else if (is_rtype && (bus.Funct == 6'h09)) begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          memto_reg = 2'b10;
        end
      end
      S_TRAP: begin
        trap_o    = 1'b1;
        pc_write  = 1'b1;
        pc_source = 3'b100;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite       = pc_write;
  assign bus.PCWriteCond   = pc_write_cond;
  assign bus.BranchNe      = branch_ne;
  assign bus.IorD          = iord;
  assign bus.MemRead       = mem_read;
  assign bus.MemWrite      = mem_write;
  assign bus.IRWrite       = ir_write;
  assign bus.RegWrite      = reg_write;
  assign bus.ExtOp         = ext_op;
  assign bus.LuiOp         = lui_op;
  assign bus.MemtoReg      = memto_reg;
  assign bus.RegDst        = reg_dst;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ALUOp         = alu_op;
  assign bus.PCSource      = pc_source;
  assign bus.trap          = trap_o;
  assign bus.trap_cause    = cause_q;
  assign bus.instr_retired = retired;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed bench for multicycle_ctrl_hs: default build plus a bne-disabled,
// halt-on-trap build driven side by side.
module tb_multicycle_ctrl_hs;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   ret_a;

  multicycle_ctrl_hs_if bus_a ();
  multicycle_ctrl_hs_if bus_b ();

  multicycle_ctrl_hs dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  multicycle_ctrl_hs #(
    .MEM_TIMEOUT (15),
    .TRAP_HALT   (1'b1),
    .ENABLE_BNE  (1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [26:0] outs_a, outs_b;
  assign outs_a = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.BranchNe, bus_a.IorD,
                   bus_a.MemRead, bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite,
                   bus_a.ExtOp, bus_a.LuiOp, bus_a.MemtoReg, bus_a.RegDst,
                   bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp, bus_a.PCSource,
                   bus_a.trap, bus_a.instr_retired};
  assign outs_b = {bus_b.PCWrite, bus_b.PCWriteCond, bus_b.BranchNe, bus_b.IorD,
                   bus_b.MemRead, bus_b.MemWrite, bus_b.IRWrite, bus_b.RegWrite,
                   bus_b.ExtOp, bus_b.LuiOp, bus_b.MemtoReg, bus_b.RegDst,
                   bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp, bus_b.PCSource,
                   bus_b.trap, bus_b.instr_retired};

  always @(posedge clk) begin
    if (reset) ret_a <= 0;
    else if (bus_a.instr_retired) ret_a <= ret_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ret_a = 0;
    reset = 1'b1;
    bus_a.OpCode = 6'h08; bus_a.Funct = 6'h00; bus_a.mem_ready = 1'b1;
    bus_b.OpCode = 6'h05; bus_b.Funct = 6'h00; bus_b.mem_ready = 1'b1;
    tick();
    tick();
    check("rst_state_a", 32'(bus_a.state_dbg), 32'd0);
    check("rst_outs_a", 32'(outs_a), 32'd0);
    check("rst_cause_a", 32'(bus_a.trap_cause), 32'd0);
    check("rst_state_b", 32'(bus_b.state_dbg), 32'd0);

    // addi with memory always ready
    reset = 1'b0;
    tick();
    check("addi_fetch_state", 32'(bus_a.state_dbg), 32'd1);
    check("addi_fetch_ctl", 32'({bus_a.MemRead, bus_a.IRWrite, bus_a.PCWrite, bus_a.IorD,
                                 bus_a.ALUSrcB}), 32'b1110_01);
    tick();
    check("addi_decode", 32'({bus_a.state_dbg, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp}),
          32'({4'd2, 2'b00, 2'b11, 4'b0000}));
    check("b_decode_state", 32'(bus_b.state_dbg), 32'd2);
    tick();
    check("addi_exec", 32'({bus_a.state_dbg, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ExtOp,
                            bus_a.LuiOp, bus_a.ALUOp}),
          32'({4'd3, 2'b01, 2'b10, 1'b1, 1'b0, 4'b0000}));
    check("b_bne_illegal", 32'({bus_b.state_dbg, bus_b.trap, bus_b.trap_cause,
                                bus_b.PCSource, bus_b.PCWrite}),
          32'({4'd11, 1'b1, 2'b01, 3'b100, 1'b1}));
    tick();
    check("addi_wb", 32'({bus_a.state_dbg, bus_a.RegWrite, bus_a.RegDst, bus_a.MemtoReg,
                          bus_a.instr_retired}),
          32'({4'd4, 1'b1, 2'b00, 2'b01, 1'b1}));
    check("b_halt_state", 32'(bus_b.state_dbg), 32'd12);
    check("b_halt_outs", 32'(outs_b), 32'd0);
    check("b_halt_cause", 32'(bus_b.trap_cause), 32'd1);
    bus_a.OpCode = 6'h23;
    tick();
    check("addi_retire_count", 32'(ret_a), 32'd1);
    check("lw_fetch_state", 32'(bus_a.state_dbg), 32'd1);

    // lw with a three-cycle memory stall
    tick();
    tick();
    check("lw_mem_addr", 32'({bus_a.state_dbg, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ExtOp}),
          32'({4'd5, 2'b01, 2'b10, 1'b1}));
    bus_a.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_a.mem_ready = (i == 3);
      #1;
      check("lw_mem_rd_hold", 32'({bus_a.state_dbg, bus_a.MemRead, bus_a.IorD}),
            32'({4'd6, 1'b1, 1'b1}));
      tick();
    end
    check("lw_wb_mem", 32'({bus_a.state_dbg, bus_a.RegWrite, bus_a.MemtoReg, bus_a.RegDst,
                            bus_a.instr_retired}),
          32'({4'd7, 1'b1, 2'b00, 2'b00, 1'b1}));
    bus_a.mem_ready = 1'b1;
    bus_a.OpCode = 6'h05;

    // bne
    tick();
    tick();
    tick();
    check("bne_branch", 32'({bus_a.state_dbg, bus_a.PCWriteCond, bus_a.BranchNe,
                             bus_a.PCSource, bus_a.ALUOp, bus_a.ALUSrcA, bus_a.ALUSrcB}),
          32'({4'd9, 1'b1, 1'b1, 3'b001, 4'b1001, 2'b01, 2'b00}));
    check("bne_retire", 32'(bus_a.instr_retired), 32'd1);
    bus_a.OpCode = 6'h00;
    bus_a.Funct = 6'h09;

    // jalr
    tick();
    tick();
    tick();
    check("jalr_jump", 32'({bus_a.state_dbg, bus_a.PCWrite, bus_a.PCSource, bus_a.RegWrite,
                            bus_a.RegDst, bus_a.MemtoReg}),
          32'({4'd10, 1'b1, 3'b011, 1'b1, 2'b01, 2'b10}));
    bus_a.OpCode = 6'h2B;
    bus_a.Funct = 6'h00;

    // sw with memory never ready: trap on the 15th wait cycle
    tick();
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      check("sw_wait_hold", 32'({bus_a.state_dbg, bus_a.MemWrite, bus_a.trap}),
            32'({4'd8, 1'b1, 1'b0}));
      tick();
    end
    check("sw_timeout_trap", 32'({bus_a.state_dbg, bus_a.trap, bus_a.trap_cause,
                                  bus_a.PCSource, bus_a.PCWrite}),
          32'({4'd11, 1'b1, 2'b10, 3'b100, 1'b1}));
    check("sw_trap_no_retire", 32'(ret_a), 32'd4);
    bus_a.mem_ready = 1'b1;
    tick();
    check("trap_refetch", 32'({bus_a.state_dbg, bus_a.trap, bus_a.trap_cause}),
          32'({4'd1, 1'b0, 2'b10}));

    // sw with ready arriving on the 15th wait cycle
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      bus_a.mem_ready = (i == 14);
      #1;
      check("sw_late_hold", 32'({bus_a.state_dbg, bus_a.MemWrite, bus_a.trap,
                                 bus_a.instr_retired}),
            32'({4'd8, 1'b1, 1'b0, (i == 14)}));
      tick();
    end
    check("sw_late_next", 32'(bus_a.state_dbg), 32'd1);
    check("sw_late_retire_count", 32'(ret_a), 32'd5);

    // reset in the middle of a store wait
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    tick();
    tick();
    tick();
    check("mid_wait_state", 32'({bus_a.state_dbg, bus_a.MemWrite}), 32'({4'd8, 1'b1}));
    reset = 1'b1;
    tick();
    check("mid_rst_a", 32'({bus_a.state_dbg, bus_a.MemWrite, bus_a.trap_cause}),
          32'({4'd0, 1'b0, 2'b00}));
    check("mid_rst_b", 32'({bus_b.state_dbg, bus_b.trap_cause}), 32'({4'd0, 2'b00}));
    reset = 1'b0;
    bus_a.mem_ready = 1'b1;
    bus_a.OpCode = 6'h3F;
    tick();
    check("post_rst_fetch", 32'({bus_a.state_dbg, bus_a.MemRead}), 32'({4'd1, 1'b1}));

    // illegal opcode on the default build refetches from the trap vector
    tick();
    tick();
    check("illegal_trap", 32'({bus_a.state_dbg, bus_a.trap, bus_a.trap_cause,
                               bus_a.PCSource}),
          32'({4'd11, 1'b1, 2'b01, 3'b100}));
    tick();
    check("illegal_refetch", 32'({bus_a.state_dbg, bus_a.trap}), 32'({4'd1, 1'b0}));
    check("illegal_no_retire", 32'(ret_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
